max_pair_dispatch: RTL

//  Feeds the two-operand max-compare FSM and collects its answers. Operand pairs arrive on a

---
 rtl/max_dispatch_pkg.sv | 24 ++
 rtl/pair_fifo.sv | 42 ++++
 rtl/max_pair_dispatch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/max_dispatch_pkg.sv
// Shared types and constants for the max-compare dispatcher.
// The state encoding, the operand pair layout and the value reported
// for an abandoned job (MAX_DISPATCH_TIMEOUT_EN builds) are kept here.
package max_dispatch_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } pair_t;

  // Result reported when a job is abandoned on timeout.
  localparam logic [WIDTH_DEF-1:0] TIMEOUT_SENTINEL = '1;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO for operand pairs.
// Pointers carry one extra wrap bit so that full and empty can be told
// apart without a separate occupancy counter.
module pair_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer update; a push while full is dropped, a pop while empty is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/max_pair_dispatch.sv
// Dispatcher between an operand-pair stream and the max-compare unit.
// Pairs are buffered, issued one at a time with a one-cycle start pulse,
// and the unit's result is presented on an output valid/ready stream.
// Optional feature: define MAX_DISPATCH_TIMEOUT_EN to abandon a job that
// does not complete within TIMEOUT cycles and add the timeout_err port.
module max_pair_dispatch
  import max_dispatch_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef MAX_DISPATCH_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic             busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("max_pair_dispatch: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("max_pair_dispatch: TIMEOUT must be >= 1");
  end

  state_t               state, state_d;
  logic                 pop, capture;
  logic                 full, empty;
  logic [2*WIDTH-1:0]   head;

  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

  pair_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef MAX_DISPATCH_TIMEOUT_EN
  localparam int              TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  logic          abort;
  wire           tmo = (tcnt == TLAST) && (state == ARM || state == WAIT);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state; ARM refuses to look at done until the unit has dropped it,
  // so a done left high by the previous job is never mistaken for this one.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    capture = 1'b0;
`ifdef MAX_DISPATCH_TIMEOUT_EN
    abort   = 1'b0;
`endif
    unique case (state)
      IDLE:  if (!empty) begin pop = 1'b1; state_d = ISSUE; end
      ISSUE: state_d = ARM;
      ARM:   if (!done) state_d = WAIT;
      WAIT:  if (done) begin capture = 1'b1; state_d = OUT; end
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MAX_DISPATCH_TIMEOUT_EN
    // A completion in the same cycle as the deadline still wins.
    if (tmo && !capture) begin
      abort   = 1'b1;
      state_d = OUT;
    end
`endif
  end

  // Registered outputs toward the compare unit and the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start     <= 1'b0;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      start <= pop;
      if (pop) begin
        a <= head[2*WIDTH-1:WIDTH];
        b <= head[WIDTH-1:0];
      end else if (state_d == OUT && state != OUT) begin
        a <= '0;
        b <= '0;
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end
`ifdef MAX_DISPATCH_TIMEOUT_EN
      else if (abort) begin
        out_valid <= 1'b1;
        out_data  <= {WIDTH{1'b1}};
      end
`endif
      else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MAX_DISPATCH_TIMEOUT_EN
  // Deadline counter over ARM+WAIT and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)                     tcnt <= '0;
      else if (state == ARM || state == WAIT) tcnt <= tcnt + 1'b1;
      if (abort) timeout_err <= 1'b1;
    end
  end
`endif

endmodule
